// File: rtl/seven_seg_capture_if.sv
// Seven-segment display bus as seen by the capture block.
//   segIn      7   segment lines {g,f,e,d,c,b,a}, active-low (driven by the display source)
//   anIn       8   anode lines, active-low, bit i = digit i (driven by the display source)
//   digits     32  decoded nibbles, digit i at [4i+3:4i]
//   digitValid 8   digit i holds a legal glyph from the current scan
//   segErr     8   last stable glyph on digit i was not a hex pattern
//   frameDone  1   one-cycle pulse when all 8 digits have committed
//   stale      1   no digit commit for the timeout period
// master = display source / monitor, slave = capture block.
interface seven_seg_capture_if;
  logic [6:0]  segIn;
  logic [7:0]  anIn;
  logic [31:0] digits;
  logic [7:0]  digitValid;
  logic [7:0]  segErr;
  logic        frameDone;
  logic        stale;

  modport master (
    output segIn, anIn,
    input  digits, digitValid, segErr, frameDone, stale
  );

  modport slave (
    input  segIn, anIn,
    output digits, digitValid, segErr, frameDone, stale
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed 8-digit seven-segment bus. Synchronizes the
// segment/anode lines, waits for a stable glyph, decodes it back to a hex nibble
// and keeps an 8-digit shadow of the display contents.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-low
//   bus  seven_seg_capture_if.slave (segIn/anIn in; digits, digitValid,
//        segErr, frameDone, stale out)
//
// Filter states (one pass per held sample):
//   state  | meaning
//   SETTLE | held sample counting identical synced samples, cnt < STABLE_CYCLES
//   COMMIT | held sample stable for STABLE_CYCLES; commit happens on this edge
//   HOLD   | already committed, waiting for the synced sample to change
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                clk,
  input logic                rst,
  seven_seg_capture_if.slave bus
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {SETTLE, COMMIT, HOLD} state_e;

  // {legal, nibble} for an active-low {g..a} pattern
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = {1'b1, 4'h0};
      7'b1111001: decode = {1'b1, 4'h1};
      7'b0100100: decode = {1'b1, 4'h2};
      7'b0110000: decode = {1'b1, 4'h3};
      7'b0011001: decode = {1'b1, 4'h4};
      7'b0010010: decode = {1'b1, 4'h5};
      7'b0000010: decode = {1'b1, 4'h6};
      7'b1111000: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0010000: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b0000011: decode = {1'b1, 4'hB};
      7'b1000110: decode = {1'b1, 4'hC};
      7'b0100001: decode = {1'b1, 4'hD};
      7'b0000110: decode = {1'b1, 4'hE};
      7'b0001110: decode = {1'b1, 4'hF};
      default:    decode = 5'b0;
    endcase
  endfunction

  // Samples are packed as {an[7:0], seg[6:0]}
  logic [14:0]       sync1_q, sync1_d;
  logic [14:0]       sync2_q, sync2_d;
  logic [14:0]       held_q, held_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [31:0]       digits_q, digits_d;
  logic [7:0]        valid_q, valid_d;
  logic [7:0]        err_q, err_d;
  logic              frame_q, frame_d;
  logic              stale_q, stale_d;
  logic [7:0]        seen_q, seen_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic       commit;
  logic [7:0] an_act;
  logic       one_active;
  logic [7:0] sel;
  logic [4:0] dec;
  logic       digit_commit;
  logic       timeout;
  logic       frame_full;

  always_comb begin
    sync1_d = {bus.anIn, bus.segIn};
    sync2_d = sync1_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    commit  = 1'b0;
    case (state_q)
      SETTLE: begin
        if (sync2_q == held_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = HOLD;
      end
      HOLD:    state_d = HOLD;
      default: state_d = SETTLE;
    endcase
    // A change restarts the window; a commit already due on this edge still
    // uses the old held sample, which was stable for the full window.
    if (sync2_q != held_q) begin
      held_d  = sync2_q;
      cnt_d   = CNT_W'(1);
      state_d = SETTLE;
    end
  end

  // Exactly one active (low) anode selects the digit; ~an is then one-hot.
  assign an_act       = ~held_q[14:7];
  assign one_active   = (an_act != 8'd0) && ((an_act & (an_act - 8'd1)) == 8'd0);
  assign sel          = one_active ? an_act : 8'd0;
  assign dec          = decode(held_q[6:0]);
  assign digit_commit = commit && one_active;
  assign timeout      = (idle_q == IDLE_LAST);
  assign frame_full   = digit_commit && ((seen_q | sel) == 8'hFF);

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    seen_d   = seen_q;
    stale_d  = stale_q;
    frame_d  = 1'b0;
    idle_d   = idle_q;

    if (digit_commit)  idle_d = '0;
    else if (!timeout) idle_d = idle_q + 1'b1;

    // A frame completing on the timeout edge wins over the timeout.
    if (timeout && !frame_full) begin
      stale_d = 1'b1;
      valid_d = 8'd0;
      seen_d  = 8'd0;
    end

    if (digit_commit) begin
      for (int i = 0; i < 8; i++) begin
        if (sel[i]) begin
          if (dec[4]) begin
            digits_d[4*i +: 4] = dec[3:0];
            valid_d[i]         = 1'b1;
            err_d[i]           = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            err_d[i]   = 1'b1;
          end
        end
      end
      seen_d = seen_d | sel;
      if (frame_full) begin
        frame_d = 1'b1;
        seen_d  = 8'd0;
        stale_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      held_q   <= '1;
      cnt_q    <= '0;
      state_q  <= SETTLE;
      digits_q <= 32'd0;
      valid_q  <= 8'd0;
      err_q    <= 8'd0;
      frame_q  <= 1'b0;
      stale_q  <= 1'b1;
      seen_q   <= 8'd0;
      idle_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      stale_q  <= stale_d;
      seen_q   <= seen_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.digitValid = valid_q;
  assign bus.segErr     = err_q;
  assign bus.frameDone  = frame_q;
  assign bus.stale      = stale_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: directed scenarios followed by random scanning,
// checked per cycle against a run-length reference model through a scoreboard queue.
module tb_seven_seg_capture;
  localparam int S = 4;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst;

  seven_seg_capture_if bus_if();

  seven_seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  valid;
    logic [7:0]  err;
    logic        frame;
    logic        stale;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model state: synchronizer delay line plus run length of identical
  // synced samples. A sample run commits once, on the edge after it reaches S.
  logic [14:0] m_pipe1, m_pipe2, m_prev;
  int          m_run, m_idle;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_valid, m_err, m_seen;
  logic        m_frame, m_stale;

  always @(posedge clk) begin : model
    logic [14:0] v, cval;
    logic        due, dcommit, timeout, full, legal;
    int          nz, idx;
    logic [3:0]  nib;
    exp_t        e;
    if (rst == 1'b0) begin
      m_pipe1 = '1; m_pipe2 = '1; m_prev = '1;
      m_run = 0; m_idle = 0;
      for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
      m_valid = 8'h00; m_err = 8'h00; m_seen = 8'h00;
      m_frame = 1'b0; m_stale = 1'b1;
    end else begin
      v    = m_pipe2;
      due  = (m_run == S);
      cval = m_prev;
      if (m_run > 0 && v == m_prev) m_run = (m_run > S) ? S + 1 : m_run + 1;
      else m_run = 1;
      m_prev  = v;
      m_pipe2 = m_pipe1;
      m_pipe1 = {bus_if.anIn, bus_if.segIn};

      nz = 0; idx = 0;
      for (int i = 0; i < 8; i++) if (cval[7+i] == 1'b0) begin nz++; idx = i; end
      dcommit = due && (nz == 1);
      timeout = (m_idle == T - 1);
      if (dcommit) m_idle = 0;
      else if (m_idle < T - 1) m_idle++;
      full = dcommit && ((m_seen | (8'b1 << idx)) == 8'hFF);
      m_frame = 1'b0;
      if (timeout && !full) begin
        m_stale = 1'b1; m_valid = 8'h00; m_seen = 8'h00;
      end
      if (dcommit) begin
        legal = 1'b0; nib = 4'h0;
        for (int n = 0; n < 16; n++) if (seg_tab[n] == cval[6:0]) begin legal = 1'b1; nib = 4'(n); end
        if (legal) begin
          m_dig[idx] = nib; m_valid[idx] = 1'b1; m_err[idx] = 1'b0;
        end else begin
          m_valid[idx] = 1'b0; m_err[idx] = 1'b1;
        end
        m_seen[idx] = 1'b1;
        if (full) begin m_frame = 1'b1; m_seen = 8'h00; m_stale = 1'b0; end
      end
    end
    for (int i = 0; i < 8; i++) e.digits[4*i +: 4] = m_dig[i];
    e.valid = m_valid; e.err = m_err; e.frame = m_frame; e.stale = m_stale;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("sb_digits", bus_if.digits, e.digits);
      chk("sb_digitValid", 32'(bus_if.digitValid), 32'(e.valid));
      chk("sb_segErr", 32'(bus_if.segErr), 32'(e.err));
      chk("sb_frameDone", 32'(bus_if.frameDone), 32'(e.frame));
      chk("sb_stale", 32'(bus_if.stale), 32'(e.stale));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n);
    bus_if.anIn = an; bus_if.segIn = seg;
    step(n);
  endtask

  task automatic scan(input int base, output int hi_cycles, output int hi_pos);
    hi_cycles = 0; hi_pos = -1;
    for (int i = 0; i < 8; i++) begin
      bus_if.anIn  = ~(8'b1 << i);
      bus_if.segIn = seg_tab[base + i];
      for (int k = 0; k < 10; k++) begin
        step(1);
        if (bus_if.frameDone) begin hi_cycles++; hi_pos = i * 16 + k; end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digits"}, bus_if.digits, 32'h0);
    chk({tag, "_valid"}, 32'(bus_if.digitValid), 32'h0);
    chk({tag, "_err"}, 32'(bus_if.segErr), 32'h0);
    chk({tag, "_frame"}, 32'(bus_if.frameDone), 32'h0);
    chk({tag, "_stale"}, 32'(bus_if.stale), 32'h1);
  endtask

  initial begin
    int hi, pos, r, len;
    logic [7:0] an;
    logic [6:0] seg;
    rst = 1'b0;
    bus_if.anIn = 8'hFF; bus_if.segIn = 7'h7F;
    step(2);
    chk_reset_outputs("reset");

    // Constant digit 0 = '3': visible after edge 7, not before
    rst = 1'b1;
    bus_if.anIn = 8'hFE; bus_if.segIn = seg_tab[3];
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("early_digit0", 32'(bus_if.digits[3:0]), 32'h0);
      chk("early_valid0", 32'(bus_if.digitValid[0]), 32'h0);
    end
    step(1);
    chk("commit_digit0", 32'(bus_if.digits[3:0]), 32'h3);
    chk("commit_valid0", 32'(bus_if.digitValid[0]), 32'h1);

    // Glitch on digit 2: '5' for 3 clocks, then '9'
    drive(8'hFB, seg_tab[5], 3);
    drive(8'hFB, seg_tab[9], 6);
    chk("glitch_pre", 32'(bus_if.digits[11:8]), 32'h0);
    chk("glitch_pre_valid", 32'(bus_if.digitValid[2]), 32'h0);
    step(1);
    chk("glitch_commit", 32'(bus_if.digits[11:8]), 32'h9);

    // Full scan 0..7
    scan(0, hi, pos);
    chk("scan1_frame_cycles", 32'(hi), 32'd1);
    chk("scan1_frame_pos", 32'(pos), 32'(7 * 16 + 6));
    chk("scan1_digits", bus_if.digits, 32'h76543210);
    chk("scan1_stale", 32'(bus_if.stale), 32'h0);
    chk("scan1_valid", 32'(bus_if.digitValid), 32'hFF);

    // Blank glyph on digit 2, then two anodes active
    drive(8'hFB, 7'h7F, 10);
    chk("blank_err", 32'(bus_if.segErr), 32'h04);
    chk("blank_valid", 32'(bus_if.digitValid), 32'hFB);
    chk("blank_digits", bus_if.digits, 32'h76543210);
    drive(8'hFC, seg_tab[1], 10);
    chk("multi_digits", bus_if.digits, 32'h76543210);
    chk("multi_err", 32'(bus_if.segErr), 32'h04);

    // Second scan 8..F, then stop: stale 64 clocks after last commit
    scan(8, hi, pos);
    chk("scan2_frame_cycles", 32'(hi), 32'd1);
    chk("scan2_digits", bus_if.digits, 32'hFEDCBA98);
    drive(8'hFF, 7'h7F, 60);
    chk("pre_timeout_stale", 32'(bus_if.stale), 32'h0);
    chk("pre_timeout_valid", 32'(bus_if.digitValid), 32'hFF);
    step(1);
    chk("timeout_stale", 32'(bus_if.stale), 32'h1);
    chk("timeout_valid", 32'(bus_if.digitValid), 32'h0);
    chk("timeout_digits", bus_if.digits, 32'hFEDCBA98);

    // Reset in the middle of a settle window
    drive(8'hFE, seg_tab[1], 2);
    rst = 1'b0;
    step(1);
    chk_reset_outputs("midreset");
    rst = 1'b1;
    step(6);
    chk("postreset_early", 32'(bus_if.digits[3:0]), 32'h0);
    step(1);
    chk("postreset_commit", 32'(bus_if.digits[3:0]), 32'h1);
    chk("postreset_valid", 32'(bus_if.digitValid[0]), 32'h1);

    // Random scanning checked by the scoreboard
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75)      an = ~(8'b1 << $urandom_range(0, 7));
      else if (r < 85) an = 8'hFF;
      else             an = 8'($urandom);
      if ($urandom_range(0, 9) < 8) seg = seg_tab[$urandom_range(0, 15)];
      else                          seg = 7'($urandom);
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 99) < 3) begin an = 8'hFF; len = 70; end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0; step(1); rst = 1'b1;
      end
      drive(an, seg, len);
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
